// File: rtl/div_acc.sv
// Divide accelerator: replaces the subtract-loop divide idiom with four injected instruction pairs.
// Define DIV_ACC_RADIX4_EN for a radix-4 divider (2 quotient bits per cycle); the default is radix-2.
module div_acc (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             StartDiv102,
    input  logic [15:0]      Divident,
    input  logic [15:0]      Divisor,
    input  logic             Abort,
    output logic             AccBusy,
    output logic             SelAccInst101,
    output logic [1:0][15:0] InstFromAcc101,
    output logic             DivDone,
    output logic             DivErr
);

`ifdef DIV_ACC_RADIX4_EN
    localparam int unsigned STEPS = 8;
    localparam int unsigned QW    = 16;
`else
    localparam int unsigned STEPS = 15;
    localparam int unsigned QW    = 15;
`endif

    typedef enum logic [1:0] {IDLE, DIV, FIX, INJ} state_t;

    state_t           state;
    logic [3:0]       step_cnt;
    logic [1:0]       pair_cnt;
    logic [14:0]      num;
    logic [14:0]      den;
    logic [QW-1:0]    quo;
    logic [14:0]      rem;
    logic [14:0]      m_res;
    logic             sel_q;
    logic [1:0][15:0] inst_q;
    logic             done_q;
    logic             err_q;

    logic [QW-1:0]    quo_nxt;
    logic [14:0]      rem_nxt;
    logic [14:0]      n_fix;
    logic [14:0]      m_fix;
    logic [15:0]      s1;
    logic             unused_msb;

    assign unused_msb = Divident[15] ^ Divisor[15];

    // One restoring step: returns {quotient bit, new partial remainder}.
    function automatic logic [15:0] rstep(input logic [14:0] r, input logic b,
                                          input logic [14:0] dv);
        logic [15:0] t;
        t = {r, b};
        if (t >= {1'b0, dv})
            return {1'b1, 15'(t - {1'b0, dv})};
        else
            return {1'b0, t[14:0]};
    endfunction

`ifdef DIV_ACC_RADIX4_EN
    logic [15:0] s2;
    always_comb begin
        s1      = rstep(rem, quo[QW-1], den);
        s2      = rstep(s1[14:0], quo[QW-2], den);
        rem_nxt = s2[14:0];
        quo_nxt = {quo[QW-3:0], s1[15], s2[15]};
    end
`else
    always_comb begin
        s1      = rstep(rem, quo[QW-1], den);
        rem_nxt = s1[14:0];
        quo_nxt = {quo[QW-2:0], s1[15]};
    end
`endif

    // Loop results derived from Q/R: M = n*d - N reduces to d-R, 0 or d, so no multiplier.
    always_comb begin
        n_fix = '0;
        m_fix = '0;
        if (num == '0) begin
            n_fix = 15'd1;
            m_fix = den;
        end else if (rem == '0) begin
            n_fix = quo[14:0];
            m_fix = '0;
        end else begin
            n_fix = quo[14:0] + 15'd1;
            m_fix = den - rem;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            pair_cnt <= '0;
            num      <= '0;
            den      <= '0;
            quo      <= '0;
            rem      <= '0;
            m_res    <= '0;
            sel_q    <= 1'b0;
            inst_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (Abort) begin
                state    <= IDLE;
                pair_cnt <= '0;
                sel_q    <= 1'b0;
                inst_q   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (StartDiv102) begin
                            if (Divisor[14:0] == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                num      <= Divident[14:0];
                                den      <= Divisor[14:0];
                                quo      <= QW'(Divident[14:0]);
                                rem      <= '0;
                                step_cnt <= 4'(STEPS - 1);
                                state    <= DIV;
                            end
                        end
                    end
                    DIV: begin
                        quo      <= quo_nxt;
                        rem      <= rem_nxt;
                        step_cnt <= step_cnt - 4'd1;
                        if (step_cnt == '0)
                            state <= FIX;
                    end
                    FIX: begin
                        m_res    <= m_fix;
                        pair_cnt <= '0;
                        sel_q    <= 1'b1;
                        inst_q   <= {16'hEC10, {1'b0, n_fix}};
                        state    <= INJ;
                    end
                    INJ: begin
                        pair_cnt <= pair_cnt + 2'd1;
                        case (pair_cnt)
                            2'd0:    inst_q <= {16'hE308, 16'h0001};
                            2'd1:    inst_q <= {16'hECD0, {1'b0, m_res}};
                            2'd2:    inst_q <= {16'hE308, 16'h0002};
                            default: begin
                                inst_q <= '0;
                                sel_q  <= 1'b0;
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Abort must squash injection in the cycle it arrives, ahead of the registered state.
    assign SelAccInst101  = sel_q & ~Abort;
    assign InstFromAcc101 = (sel_q && !Abort) ? inst_q : '0;
    assign AccBusy        = (state != IDLE);
    assign DivDone        = done_q;
    assign DivErr         = err_q;

endmodule

// File: tb/tb_div_acc.sv
// Scoreboard bench for div_acc: random and directed divides against a do-while loop model.
module tb_div_acc;

`ifdef DIV_ACC_RADIX4_EN
    localparam int STEPS = 8;
`else
    localparam int STEPS = 15;
`endif
    localparam int K_PAIR = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic             Clk;
    logic             Reset;
    logic             StartDiv102;
    logic [15:0]      Divident;
    logic [15:0]      Divisor;
    logic             Abort;
    logic             AccBusy;
    logic             SelAccInst101;
    logic [1:0][15:0] InstFromAcc101;
    logic             DivDone;
    logic             DivErr;

    div_acc dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .StartDiv102    (StartDiv102),
        .Divident       (Divident),
        .Divisor        (Divisor),
        .Abort          (Abort),
        .AccBusy        (AccBusy),
        .SelAccInst101  (SelAccInst101),
        .InstFromAcc101 (InstFromAcc101),
        .DivDone        (DivDone),
        .DivErr         (DivErr)
    );

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] a;
        logic [15:0] c;
    } exp_t;

    exp_t q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   busy_from = 1;
    int   busy_to   = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Architectural behaviour of the replaced loop: D=N; do { D-=d; n++ } while (D>0).
    function automatic void model(input int nn, input int dd, output int n_out, output int m_out);
        int dacc;
        int k;
        dacc = nn;
        k    = 0;
        do begin
            dacc = dacc - dd;
            k    = k + 1;
        end while (dacc > 0);
        n_out = k;
        m_out = -dacc;
    endfunction

    task automatic push(input int k, input int cy, input logic [15:0] a, input logic [15:0] c);
        exp_t e;
        e.kind = k;
        e.cyc  = cy;
        e.a    = a;
        e.c    = c;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] nv, input logic [15:0] dv);
        int t;
        int nres;
        int mres;
        t = cyc;
        Divident    = nv;
        Divisor     = dv;
        StartDiv102 = 1'b1;
        if (dv[14:0] == 15'd0) begin
            push(K_ERR, t + 1, 16'h0, 16'h0);
        end else begin
            model(int'(nv[14:0]), int'(dv[14:0]), nres, mres);
            push(K_PAIR, t + STEPS + 2, 16'(nres), 16'hEC10);
            push(K_PAIR, t + STEPS + 3, 16'h0001, 16'hE308);
            push(K_PAIR, t + STEPS + 4, 16'(mres), 16'hECD0);
            push(K_PAIR, t + STEPS + 5, 16'h0002, 16'hE308);
            push(K_DONE, t + STEPS + 6, 16'h0, 16'h0);
            busy_from = t + 1;
            busy_to   = t + STEPS + 5;
        end
        tick();
        StartDiv102 = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || cyc <= busy_to + 1) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL idle_timeout: queue=%0d entries left, required 0 within 100 cycles", q.size());
            q.delete();
        end
        tick();
    endtask

    task automatic wait_until(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge Clk) begin
        logic exp_busy;
        exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
        checks++;
        if (AccBusy !== exp_busy) begin
            errors++;
            $display("FAIL busy@%0d: got %b required %b", cyc, AccBusy, exp_busy);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing kind=%0d@%0d: got nothing required event", q[0].kind, q[0].cyc);
            void'(q.pop_front());
        end
        checks++;
        if (SelAccInst101 === 1'b1) begin
            if (q.size() > 0 && q[0].kind == K_PAIR && q[0].cyc == cyc) begin
                if (InstFromAcc101[0] !== q[0].a || InstFromAcc101[1] !== q[0].c) begin
                    errors++;
                    $display("FAIL pair@%0d: got {%h,%h} required {%h,%h}", cyc,
                             InstFromAcc101[0], InstFromAcc101[1], q[0].a, q[0].c);
                end
                void'(q.pop_front());
            end else begin
                errors++;
                $display("FAIL sel@%0d: got 1 required 0", cyc);
            end
        end else if (InstFromAcc101 !== '0) begin
            errors++;
            $display("FAIL inst_gate@%0d: got %h required 0", cyc, InstFromAcc101);
        end
        if (DivDone !== 1'b0) begin
            checks++;
            if (q.size() > 0 && q[0].kind == K_DONE && q[0].cyc == cyc) begin
                void'(q.pop_front());
            end else begin
                errors++;
                $display("FAIL done@%0d: got %b required 0", cyc, DivDone);
            end
        end
        if (DivErr !== 1'b0) begin
            checks++;
            if (q.size() > 0 && q[0].kind == K_ERR && q[0].cyc == cyc) begin
                void'(q.pop_front());
            end else begin
                errors++;
                $display("FAIL err@%0d: got %b required 0", cyc, DivErr);
            end
        end
    end

    initial begin
        int t;
        Reset       = 1'b0;
        StartDiv102 = 1'b0;
        Divident    = '0;
        Divisor     = '0;
        Abort       = 1'b0;
        #2;
        checks++;
        if ({AccBusy, SelAccInst101, DivDone, DivErr} !== 4'b0 || InstFromAcc101 !== '0) begin
            errors++;
            $display("FAIL reset: got busy=%b sel=%b done=%b err=%b inst=%h required all 0",
                     AccBusy, SelAccInst101, DivDone, DivErr, InstFromAcc101);
        end
        repeat (3) tick();
        Reset = 1'b1;
        tick();

        issue(16'd20000, 16'd10);
        wait_idle();
        issue(16'd7, 16'd2);
        wait_idle();
        issue(16'd0, 16'd5);
        wait_idle();
        issue(16'd100, 16'd0);
        wait_idle();
        issue(16'h8007, 16'h8002);
        wait_idle();
        issue(16'd32767, 16'd1);
        wait_idle();
        issue(16'd5, 16'd32767);
        wait_idle();

        // Second start mid-divide is ignored.
        t = cyc;
        issue(16'd50, 16'd7);
        wait_until(t + 5);
        Divident    = 16'd9999;
        Divisor     = 16'd3;
        StartDiv102 = 1'b1;
        tick();
        StartDiv102 = 1'b0;
        wait_idle();

        // Abort during DIV, then a restart four cycles later.
        t = cyc;
        issue(16'd1234, 16'd5);
        wait_until(t + 8);
        Abort = 1'b1;
        q.delete();
        busy_to = t + 8;
        tick();
        Abort = 1'b0;
        wait_until(t + 12);
        issue(16'd1234, 16'd5);
        wait_idle();

        // Abort during injection squashes the pair in the same cycle.
        t = cyc;
        issue(16'd999, 16'd7);
        wait_until(t + STEPS + 3);
        Abort = 1'b1;
        q.delete();
        busy_to = t + STEPS + 3;
        tick();
        Abort = 1'b0;
        wait_idle();

        // Abort beats a simultaneous start, including a zero-divisor one.
        Abort       = 1'b1;
        StartDiv102 = 1'b1;
        Divident    = 16'd77;
        Divisor     = 16'd3;
        tick();
        Divisor     = 16'd0;
        tick();
        Abort       = 1'b0;
        StartDiv102 = 1'b0;
        repeat (4) tick();

        // Reset mid-divide, then start on the first edge after release.
        issue(16'd4321, 16'd9);
        repeat (5) tick();
        Reset = 1'b0;
        q.delete();
        busy_to = cyc - 1;
        repeat (2) tick();
        Reset = 1'b1;
        issue(16'd4321, 16'd9);
        wait_idle();

        for (int i = 0; i < 16; i++) begin
            logic [15:0] nv;
            logic [15:0] dv;
            nv = 16'($urandom);
            if ($urandom_range(0, 5) == 0) nv[14:0] = '0;
            dv = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       dv[14:0] = '0;
                1:       dv[14:0] = 15'($urandom_range(1, 20));
                default: ;
            endcase
            issue(nv, dv);
            wait_idle();
        end

        repeat (3) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
